// File: rtl/demux_slot_sequencer.sv
// Serial-to-slot sequencer feeding a 1:4 demux: each accepted bit is launched on out with
// a round-robin {s0,s1} select, held for at least two cycles, grouped into frames and bursts.
module demux_slot_sequencer #(
  parameter int unsigned FRAMES = 8,
  parameter int unsigned FW     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic out,
  output logic s0,
  output logic s1,
  output logic out_stb,
  output logic frame_done,
  output logic burst_done,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  localparam logic [FW-1:0] LastFrm = FW'(FRAMES - 1);

  state_e        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          out_q, out_d;
  logic [1:0]    sel_q, sel_d;
  logic          stb_q, stb_d;
  logic          fdone_q, fdone_d;
  logic          bdone_q, bdone_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    frm_d   = frm_q;
    out_d   = out_q;
    sel_d   = sel_q;
    stb_d   = 1'b0;
    fdone_d = 1'b0;
    bdone_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          slot_d  = '0;
          frm_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // abort wins over a coincident accept; the offered bit is dropped
        if (abort) begin
          state_d = StIdle;
        end else if (din_valid) begin
          out_d   = din;
          sel_d   = slot_q;
          stb_d   = 1'b1;
          slot_d  = slot_q + 2'd1;
          state_d = StHold;
          if (slot_q == 2'd3) begin
            fdone_d = 1'b1;
            frm_d   = frm_q + 1'b1;
            bdone_d = (frm_q == LastFrm);
          end
        end
      end
      StHold: begin
        // bdone_q is only ever high in the HOLD cycle following the final launch
        if (abort || bdone_q) state_d = StIdle;
        else                  state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      slot_q  <= '0;
      frm_q   <= '0;
      out_q   <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      fdone_q <= 1'b0;
      bdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      frm_q   <= frm_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      fdone_q <= fdone_d;
      bdone_q <= bdone_d;
    end
  end

  assign din_ready  = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign out        = out_q;
  assign s0         = sel_q[1];
  assign s1         = sel_q[0];
  assign out_stb    = stb_q;
  assign frame_done = fdone_q;
  assign burst_done = bdone_q;

endmodule

// File: tb/tb_demux_slot_sequencer.sv
// Directed bench: a single-frame instance driven from a vector table, and a three-frame
// instance exercised with hand-written multi-frame, abort and reset sequences.
module tb_demux_slot_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic abort = 1'b0, din = 1'b0, din_valid = 1'b0;

  logic rdy1, out1, s0_1, s1_1, stb1, fd1, bd1, busy1;
  logic rdy3, out3, s0_3, s1_3, stb3, fd3, bd3, busy3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_slot_sequencer #(.FRAMES(1), .FW(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .din(din),
    .din_valid(din_valid), .din_ready(rdy1), .out(out1), .s0(s0_1), .s1(s1_1),
    .out_stb(stb1), .frame_done(fd1), .burst_done(bd1), .busy(busy1)
  );

  demux_slot_sequencer #(.FRAMES(3), .FW(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .din(din),
    .din_valid(din_valid), .din_ready(rdy3), .out(out3), .s0(s0_3), .s1(s1_3),
    .out_stb(stb3), .frame_done(fd3), .burst_done(bd3), .busy(busy3)
  );

  // Observation vector order: {out, s0, s1, out_stb, frame_done, burst_done, din_ready, busy}
  function automatic logic [7:0] obs1();
    return {out1, s0_1, s1_1, stb1, fd1, bd1, rdy1, busy1};
  endfunction

  function automatic logic [7:0] obs3();
    return {out3, s0_3, s1_3, stb3, fd3, bd3, rdy3, busy3};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Offers one bit to dut3 and waits (bounded) for its launch; obs is X on timeout.
  task automatic send3(input logic b, output logic [7:0] obs);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (stb3) begin
        ok = 1'b1;
        break;
      end
    end
    obs = ok ? obs3() : 8'bx;
  endtask

  typedef struct packed {
    logic       st;
    logic       dv;
    logic       d;
    logic       ab;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [7:0]  o;
    logic [11:0] pat;
    logic [1:0]  sl;

    // start, din_valid, din, abort, expected
    vecs[0]  = {4'b1000, 8'b0_00_000_11};  // start -> LOAD
    vecs[1]  = {4'b1110, 8'b1_00_100_01};  // bit 1 to slot a; start in LOAD ignored
    vecs[2]  = {4'b0100, 8'b1_00_000_11};  // HOLD: din_valid not accepted
    vecs[3]  = {4'b1100, 8'b0_01_100_01};  // bit 0 to slot b
    vecs[4]  = {4'b0100, 8'b0_01_000_11};
    vecs[5]  = {4'b0110, 8'b1_10_100_01};  // bit 1 to slot c
    vecs[6]  = {4'b0100, 8'b1_10_000_11};
    vecs[7]  = {4'b0110, 8'b1_11_111_01};  // slot d: frame and burst done
    vecs[8]  = {4'b0100, 8'b1_11_000_00};  // idle one cycle later
    vecs[9]  = {4'b0100, 8'b1_11_000_00};  // din_valid in IDLE ignored
    vecs[10] = {4'b1000, 8'b1_11_000_11};  // restart; outputs hold
    vecs[11] = {4'b0100, 8'b0_00_100_01};  // restarts at slot a
    vecs[12] = {4'b0000, 8'b0_00_000_11};
    vecs[13] = {4'b0000, 8'b0_00_000_11};  // five stalled LOAD cycles
    vecs[14] = {4'b0000, 8'b0_00_000_11};
    vecs[15] = {4'b0000, 8'b0_00_000_11};
    vecs[16] = {4'b0000, 8'b0_00_000_11};
    vecs[17] = {4'b0000, 8'b0_00_000_11};
    vecs[18] = {4'b0110, 8'b1_01_100_01};  // resumes at slot b, no skip
    vecs[19] = {4'b0001, 8'b1_01_000_00};  // abort in HOLD

    #2;
    check("reset1", obs1(), 8'h00);
    check("reset3", obs3(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start1 = vecs[i].st;
      din_valid = vecs[i].dv;
      din = vecs[i].d;
      abort = vecs[i].ab;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs1(), vecs[i].exp);
    end
    @(negedge clk);
    start1 = 1'b0;
    din_valid = 1'b0;
    abort = 1'b0;

    // Three-frame burst, 12 bits
    pat = 12'b1011_0010_1110;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sl = 2'(i);
      send3(pat[i], o);
      check($sformatf("burst_bit%0d", i), o,
            {pat[i], sl, 1'b1, sl == 2'd3, i == 11, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1;
    check("burst_idle", obs3(), {pat[11], 2'b11, 5'b00000});
    @(negedge clk);
    din_valid = 1'b0;

    // Abort coincident with the 6th accept
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    send3(1'b0, o);
    send3(1'b1, o);
    send3(1'b1, o);
    send3(1'b0, o);
    send3(1'b1, o);
    check("abort_bit5", o, 8'b1_00_100_01);
    @(negedge clk);
    din = 1'b0;
    @(posedge clk);
    #1;
    check("abort_pre", obs3(), 8'b1_00_000_11);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle", obs3(), 8'b1_00_000_00);
    @(negedge clk);
    abort = 1'b0;
    din_valid = 1'b0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    send3(1'b0, o);
    check("restart_slot0", o, 8'b0_00_100_01);
    send3(1'b1, o);
    check("restart_slot1", o, 8'b1_01_100_01);

    // Asynchronous reset while in LOAD
    @(negedge clk);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_load", obs3(), 8'b1_01_000_11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", obs3(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", obs3(), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_slot_sequencer.md
# demux_slot_sequencer

Upstream driver for the 1:4 behavioural demultiplexer. Accepts a serial bit stream over a valid/ready handshake and presents each bit on `out` with the matching `s0`/`s1` channel select, in round-robin slot order a, b, c, d. The bit-to-channel order is fixed. A burst is a programmed number of 4-slot frames, and the block reports frame and burst completion.

## Interface
Parameters:
- `FRAMES`, default 8: frames per burst; legal range 1..255.
- `FW`, default 8: frame-counter width; `FRAMES` must be ≤ 2^FW−1.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: sampled in IDLE only; begins a burst.
- `abort`, input, 1: synchronous; ends the burst from any non-IDLE state.
- `din`, input, 1: serial data bit.
- `din_valid`, input, 1: `din` is valid.
- `din_ready`, output, 1: block can accept `din` this cycle.
- `out`, output, 1: data bit to the demux `out` input.
- `s0`, output, 1: demux select MSB.
- `s1`, output, 1: demux select LSB.
- `out_stb`, output, 1: one-cycle pulse; `out`/`s0`/`s1` were updated this cycle.
- `frame_done`, output, 1: one-cycle pulse when slot 3 of a frame is launched.
- `burst_done`, output, 1: one-cycle pulse when the last frame completes.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Internal state:
  - 2-bit slot counter `slot`.
  - `FW`-bit frame counter `frm`.
  - FSM with states IDLE, LOAD, HOLD.
- Select mapping: `{s0,s1} = slot`.
  - Slot 0 → a (00), slot 1 → b (01), slot 2 → c (10), slot 3 → d (11).
- IDLE:
  - `din_ready`=0, `busy`=0.
  - On `start`=1: clear `slot` and `frm`, go to LOAD.
- LOAD:
  - `din_ready`=1.
  - On accept (`din_valid & din_ready`), at the next edge:
    - `out`←`din`, `{s0,s1}`←`slot`, `out_stb`=1.
    - `slot`←`slot`+1, wrapping 3→0.
    - Go to HOLD.
  - With no accept, stay in LOAD; all outputs hold.
- HOLD:
  - `din_ready`=0 for exactly one cycle, so `out`/`s0`/`s1` are stable for at least 2 cycles before they can change again.
  - Then go to LOAD, or go to IDLE if the burst ended.
- Frame end: when slot 3 is launched:
  - `frame_done`=1 in the same cycle as `out_stb`.
  - `frm`←`frm`+1.
- Burst end: if `frm` was `FRAMES`−1 when slot 3 is launched:
  - `burst_done`=1, coincident with `frame_done`.
  - HOLD then goes to IDLE.
- `abort`: in LOAD or HOLD, go to IDLE at the next edge. Priority over a coincident accept; that bit is dropped.
  - `out`/`s0`/`s1` keep their last values.
  - No `frame_done`/`burst_done` is issued.
  - `slot` and `frm` are not cleared until the next `start`.
- `start` outside IDLE is ignored.
- `din` is ignored whenever `din_ready`=0.

## Timing
- Reset (`rst_n`=0, asynchronous): all outputs 0, FSM in IDLE, `slot`=0, `frm`=0.
- Reset release: first active edge with `rst_n`=1.
- Reset mid-burst: immediate return to reset values; no completion pulses.
- `start` at edge N → `din_ready`=1 in cycle N+1.
- Accept at edge M → `out`/`s`/`out_stb` updated in cycle M+1, and `din_ready`=0 in cycle M+1 (HOLD).
- Earliest next accept is at edge M+2.
- Peak throughput: 1 bit per 2 cycles. A full frame takes at least 8 cycles.
- All outputs are registered; none are combinational from inputs.
- `burst_done` is followed by `busy`=0 one cycle later.

## Test plan
- Reset values: assert `rst_n`=0 mid-LOAD → all outputs 0 immediately; after release, `busy`=0 and `din_ready`=0.
- Round-robin order: `FRAMES`=1, `start`, then `din_valid` held high with bits 1,0,1,1.
  - → `{s0,s1}` = 00, 01, 10, 11 on successive `out_stb`; `out` = 1, 0, 1, 1.
  - → `frame_done` and `burst_done` on the 4th `out_stb`; `busy`=0 one cycle later.
- Backpressure/stall: drop `din_valid` for 5 cycles in LOAD → outputs held, no `out_stb`; resume → next slot continues without a skip.
- Multi-frame wrap: `FRAMES`=3, 12 bits sent.
  - → `frame_done` after bits 4, 8, 12; `burst_done` only after bit 12.
  - → slot wraps 3→0 between frames.
- Abort: `abort` coincident with an accept on bit 6.
  - → bit dropped, IDLE next cycle, `out`/`s` keep bit-5 values, no `burst_done`.
  - → a new `start` restarts at slot 0.
- Ignored inputs: `start` pulsed during LOAD → no effect; `din_valid` during HOLD → not accepted, `out_stb` stays 0.
